// File: rtl/nfc_command_reset_multiway.sv
// Multi-way NAND RESET (FFh) / SYNC RESET (FCh) sequencer: issues the command to each
// selected way in ascending order and follows that way's R/B busy/ready handshake.
module nfc_command_reset_multiway #(
  parameter int         NumberOfWays  = 4,
  parameter logic [5:0] CommandID     = 6'b000001,
  parameter logic [4:0] TargetID      = 5'b00101,
  parameter int         RBLowWindow   = 64,
  parameter int         TimeoutCycles = 1048576,
  parameter int         TimerWidth    = 24
) (
  input  logic                    iSystemClock,
  input  logic                    iReset,
  input  logic [5:0]              iOpcode,
  input  logic                    iCMDValid,
  output logic                    oCMDReady,
  input  logic [NumberOfWays-1:0] iWaySelect,
  input  logic                    iResetMode,
  output logic                    oStart,
  output logic                    oLastStep,
  output logic [NumberOfWays-1:0] oTimeoutWays,
  output logic [7:0]              oACG_Command,
  output logic [2:0]              oACG_CommandOption,
  input  logic [7:0]              iACG_Ready,
  input  logic [7:0]              iACG_LastStep,
  output logic [NumberOfWays-1:0] oACG_TargetWay,
  output logic [15:0]             oACG_NumOfData,
  output logic                    oACG_CASelect,
  output logic [39:0]             oACG_CAData,
  input  logic [NumberOfWays-1:0] iACG_ReadyBusy
);

  typedef enum logic [8:0] {
    stateReset      = 9'b000000001,
    stateReady      = 9'b000000010,
    stateLatch      = 9'b000000100,
    stateSelect     = 9'b000001000,
    stateCmdIssue   = 9'b000010000,
    stateWaitRBLow  = 9'b000100000,
    stateWaitRBHigh = 9'b001000000,
    stateNext       = 9'b010000000,
    stateDone       = 9'b100000000
  } state_t;

  state_t                  state;
  logic [NumberOfWays-1:0] pendingWays;
  logic [NumberOfWays-1:0] currentWay;
  logic                    resetMode;
  logic [TimerWidth-1:0]   timer;
  logic [NumberOfWays-1:0] rbStage1;
  logic                    rbSampled;

  logic                    accept;
  logic [NumberOfWays-1:0] remainingWays;
  logic [NumberOfWays-1:0] firstWay;
  logic [NumberOfWays-1:0] nextWay;
  logic                    unusedInputs;

  // Isolates the lowest set bit, so ways are always served in ascending index order.
  function automatic logic [NumberOfWays-1:0] lowestOf(input logic [NumberOfWays-1:0] mask);
    lowestOf = mask & (~mask + NumberOfWays'(1));
  endfunction

  assign oStart        = (iOpcode == CommandID) & iCMDValid;
  assign accept        = oStart & oCMDReady;
  assign remainingWays = pendingWays & ~currentWay;
  assign firstWay      = lowestOf(iWaySelect);
  assign nextWay       = lowestOf(remainingWays);
  assign unusedInputs  = ^{iACG_Ready[7], iACG_LastStep[7], iACG_LastStep[5:0], TargetID};

  // R/B is observed only for the way being served; the FSM acts on the second stage.
  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      rbStage1  <= '0;
      rbSampled <= 1'b0;
    end else begin
      rbStage1  <= iACG_ReadyBusy & currentWay;
      rbSampled <= |rbStage1;
    end
  end

  always_ff @(posedge iSystemClock) begin
    if (iReset) begin
      state              <= stateReset;
      oCMDReady          <= 1'b1;
      oLastStep          <= 1'b0;
      oTimeoutWays       <= '0;
      oACG_Command       <= 8'h00;
      oACG_CommandOption <= 3'd0;
      oACG_NumOfData     <= 16'h0000;
      oACG_CASelect      <= 1'b1;
      oACG_CAData        <= 40'h0;
      oACG_TargetWay     <= '1;
      pendingWays        <= '0;
      currentWay         <= '0;
      resetMode          <= 1'b0;
      timer              <= '0;
    end else begin
      oLastStep <= 1'b0;
      case (state)
        stateReset: begin
          state     <= stateReady;
          oCMDReady <= 1'b1;
        end
        stateReady: begin
          if (accept) begin
            state     <= stateLatch;
            oCMDReady <= 1'b0;
          end
        end
        stateLatch: begin
          pendingWays  <= iWaySelect;
          resetMode    <= iResetMode;
          oTimeoutWays <= '0;
          if (iWaySelect != '0) begin
            state          <= stateSelect;
            currentWay     <= firstWay;
            oACG_TargetWay <= ~firstWay;
          end else begin
            state     <= stateDone;
            oLastStep <= 1'b1;
          end
        end
        stateSelect: begin
          if (iACG_Ready[6:0] == 7'h7F) begin
            state              <= stateCmdIssue;
            oACG_Command       <= 8'h40;
            oACG_CommandOption <= 3'd0;
            oACG_NumOfData     <= 16'h0001;
            oACG_CASelect      <= 1'b1;
            oACG_CAData        <= {(resetMode ? 8'hFC : 8'hFF), 32'h0};
          end
        end
        stateCmdIssue: begin
          if (iACG_LastStep[6]) begin
            state        <= stateWaitRBLow;
            oACG_Command <= 8'h00;
            timer        <= '0;
          end
        end
        // A busy pulse that never shows up within the window is treated as missed.
        stateWaitRBLow: begin
          if (!rbSampled || (timer == TimerWidth'(RBLowWindow - 1))) begin
            state <= stateWaitRBHigh;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        stateWaitRBHigh: begin
          if (rbSampled) begin
            state          <= stateNext;
            oACG_TargetWay <= '1;
          end else if (timer == TimerWidth'(TimeoutCycles - 1)) begin
            state          <= stateNext;
            oACG_TargetWay <= '1;
            oTimeoutWays   <= oTimeoutWays | currentWay;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        stateNext: begin
          pendingWays <= remainingWays;
          if (remainingWays != '0) begin
            state          <= stateSelect;
            currentWay     <= nextWay;
            oACG_TargetWay <= ~nextWay;
          end else begin
            state      <= stateDone;
            currentWay <= '0;
            oLastStep  <= 1'b1;
          end
        end
        stateDone: begin
          state     <= stateReady;
          oCMDReady <= 1'b1;
        end
        default: begin
          state <= stateReset;
        end
      endcase
    end
  end

endmodule
